// File: rtl/reduce_gate_pipe.sv
// Pipelined WIDTH-bit reduction gate (OR/AND/XOR/majority) with valid/ready
// handshakes, a 2-entry result buffer and a saturating count of '1' results.
`timescale 1ns/1ps
module reduce_gate_pipe #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] ones_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state;
    occ_t             state_next;
    logic             push;
    logic             pop;
    logic             red_y;
    logic [6:0]       pop_cnt;
    logic [7:0]       pop_x2;
    logic             head_y;
    logic [1:0]       head_mode;
    logic             tail_y;
    logic [1:0]       tail_mode;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_y     = head_y;
    assign out_mode  = head_mode;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + 7'(in_data[i]);
        end
    end

    // Majority is strict: an even-WIDTH tie reduces to 0.
    assign pop_x2 = {pop_cnt, 1'b0};

    always_comb begin
        red_y = 1'b0;
        unique case (in_mode)
            2'b00:   red_y = |in_data;
            2'b01:   red_y = &in_data;
            2'b10:   red_y = ^in_data;
            2'b11:   red_y = (pop_x2 > 8'(WIDTH));
            default: red_y = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (!push && pop) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Head is always the oldest result; tail only holds the second entry when FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_y    <= 1'b0;
            head_mode <= 2'b00;
            tail_y    <= 1'b0;
            tail_mode <= 2'b00;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head_y    <= red_y;
                        head_mode <= in_mode;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_y    <= red_y;
                        head_mode <= in_mode;
                    end else if (push) begin
                        tail_y    <= red_y;
                        tail_mode <= in_mode;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_y    <= tail_y;
                        head_mode <= tail_mode;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (cnt_clr) begin
            ones_cnt <= '0;
        end else if (pop && head_y && (ones_cnt != CNT_MAX)) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Scoreboard bench for reduce_gate_pipe: a WIDTH=3/CNT_W=2 instance for the
// main scenarios and a WIDTH=4 instance for the even-width majority tie.
`timescale 1ns/1ps
module tb_reduce_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = '0;
    logic [1:0] in_mode = '0;
    logic       out_ready = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_y;
    logic [1:0] out_mode;
    logic [1:0] ones_cnt;

    logic       in_valid4 = 1'b0;
    logic [3:0] in_data4 = '0;
    logic [1:0] in_mode4 = '0;
    logic       out_ready4 = 1'b1;
    logic       cnt_clr4 = 1'b0;
    logic       in_ready4;
    logic       out_valid4;
    logic       out_y4;
    logic [1:0] out_mode4;
    logic [7:0] ones_cnt4;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp4_q[$];

    logic [2:0] st_data [10] = '{3'b001, 3'b000, 3'b111, 3'b101, 3'b011,
                                 3'b111, 3'b110, 3'b100, 3'b010, 3'b000};
    logic [1:0] st_mode [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                                 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
    logic       st_y    [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    reduce_gate_pipe #(.WIDTH(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_mode(out_mode),
        .ones_cnt(ones_cnt), .cnt_clr(cnt_clr)
    );

    reduce_gate_pipe #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_y(out_y4), .out_mode(out_mode4),
        .ones_cnt(ones_cnt4), .cnt_clr(cnt_clr4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out, expected a handshake", name);
    endtask

    // Monitors pop the expected {mode,y} whenever the DUT delivers a result.
    always @(negedge clk) begin : monitor_main
        logic [2:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                reportTimeout("sb_unexpected_result");
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_y", int'(out_y), int'(e[0]));
                checkOutput("sb_mode", int'(out_mode), int'(e[2:1]));
            end
        end
    end

    always @(negedge clk) begin : monitor_wide
        logic [2:0] e;
        if (!rst && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                reportTimeout("sb4_unexpected_result");
            end else begin
                e = exp4_q.pop_front();
                checkOutput("sb4_y", int'(out_y4), int'(e[0]));
                checkOutput("sb4_mode", int'(out_mode4), int'(e[2:1]));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] d, input logic [1:0] m, input logic y);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({m, y});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        reportTimeout("push_accept");
    endtask

    task automatic applyStimulusWide(input logic [3:0] d, input logic [1:0] m, input logic y);
        in_valid4 = 1'b1;
        in_data4  = d;
        in_mode4  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready4) begin
                exp4_q.push_back({m, y});
                @(posedge clk);
                #1;
                in_valid4 = 1'b0;
                return;
            end
        end
        in_valid4 = 1'b0;
        reportTimeout("push4_accept");
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!out_valid && !out_valid4 && exp_q.size() == 0 && exp4_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        reportTimeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic clearCount();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("cnt_clear", int'(ones_cnt), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_y", int'(out_y), 0);
        checkOutput("rst_out_mode", int'(out_mode), 0);
        checkOutput("rst_ones_cnt", int'(ones_cnt), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] mode sweep on 3'b100");
        out_ready = 1'b1;
        applyStimulus(3'b100, 2'b00, 1'b1);
        applyStimulus(3'b100, 2'b01, 1'b0);
        applyStimulus(3'b100, 2'b10, 1'b1);
        applyStimulus(3'b100, 2'b11, 1'b0);
        waitDrain();
        checkOutput("sweep_ones_cnt", int'(ones_cnt), 2);

        $display("[TB] majority, WIDTH=3 and WIDTH=4");
        applyStimulus(3'b011, 2'b11, 1'b1);
        applyStimulus(3'b001, 2'b11, 1'b0);
        applyStimulusWide(4'b0011, 2'b11, 1'b0);
        applyStimulusWide(4'b0111, 2'b11, 1'b1);
        applyStimulusWide(4'b1111, 2'b01, 1'b1);
        applyStimulusWide(4'b0110, 2'b10, 1'b0);
        waitDrain();
        checkOutput("maj_ones_cnt", int'(ones_cnt), 3);
        checkOutput("wide_ones_cnt", int'(ones_cnt4), 2);
        clearCount();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(3'b111, 2'b01, 1'b1);
        applyStimulus(3'b000, 2'b00, 1'b0);
        checkOutput("bp_in_ready_full", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = 3'b110;
        in_mode  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_held", int'(in_ready), 0);
            checkOutput("bp_out_y_stable", int'(out_y), 1);
            checkOutput("bp_out_mode_stable", int'(out_mode), 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_before_pop", int'(in_ready), 0);
        @(negedge clk);
        checkOutput("bp_in_ready_after_pop", int'(in_ready), 1);
        @(posedge clk);
        #1;
        applyStimulus(3'b110, 2'b10, 1'b0);
        waitDrain();
        checkOutput("bp_ones_cnt", int'(ones_cnt), 1);

        $display("[TB] streaming push+pop in ONE");
        applyStimulus(3'b010, 2'b00, 1'b1);
        checkOutput("stream_in_ready_pre", int'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(st_data[i], st_mode[i], st_y[i]);
            checkOutput("stream_out_valid", int'(out_valid), 1);
            checkOutput("stream_in_ready", int'(in_ready), 1);
        end
        waitDrain();

        $display("[TB] counter saturation and clear priority");
        clearCount();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b111, 2'b00, 1'b1);
        end
        waitDrain();
        checkOutput("sat_ones_cnt", int'(ones_cnt), 3);
        clearCount();
        out_ready = 1'b0;
        applyStimulus(3'b001, 2'b00, 1'b1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        checkOutput("clr_wins_ones_cnt", int'(ones_cnt), 0);
        checkOutput("clr_wins_out_valid", int'(out_valid), 0);

        $display("[TB] async reset while FULL");
        out_ready = 1'b1;
        applyStimulus(3'b100, 2'b00, 1'b1);
        waitDrain();
        checkOutput("pre_rst_ones_cnt", int'(ones_cnt), 1);
        out_ready = 1'b0;
        applyStimulus(3'b111, 2'b00, 1'b1);
        applyStimulus(3'b111, 2'b01, 1'b1);
        checkOutput("pre_rst_full", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", int'(out_valid), 0);
        checkOutput("async_rst_ones_cnt", int'(ones_cnt), 0);
        checkOutput("async_rst_out_y", int'(out_y), 0);
        checkOutput("async_rst_out_mode", int'(out_mode), 0);
        exp_q.delete();
        in_valid = 1'b1;
        in_data  = 3'b111;
        in_mode  = 2'b01;
        @(posedge clk);
        #1;
        checkOutput("rst_push_discarded", int'(out_valid), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        applyStimulus(3'b100, 2'b10, 1'b1);
        waitDrain();
        checkOutput("post_rst_ones_cnt", int'(ones_cnt), 1);

        checkOutput("sb_leftover", exp_q.size(), 0);
        checkOutput("sb4_leftover", exp4_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
